// File: rtl/data_mem_bytelane.sv
// Byte-lane data memory: b/h/w loads and stores, registered read, clear sweep.
// Optional per-lane even parity when DMEM_PARITY_EN is defined.
module data_mem_bytelane #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              str,
  input  logic              ld,
  input  logic              clr,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W+1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              misalign,
`ifdef DMEM_PARITY_EN
  output logic              parity_err,
`endif
  output logic              busy
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] widx;
  logic [1:0]        off;
  logic              in_clr;
  logic              clr_go;
  logic              req;
  logic              aligned;
  logic              acc;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rword;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [DATA_W-1:0] ext;

  assign widx    = addr[ADDR_W+1:2];
  assign off     = addr[1:0];
  assign in_clr  = (state == CLEAR);
  assign clr_go  = sel & clr & ~in_clr;
  assign req     = sel & ~in_clr & ~clr & (str | ld);
  assign aligned = (size == 2'b00)
                 | ((size == 2'b01) & ~off[0])
                 | ((size == 2'b10) & (off == 2'b00));
  assign acc     = req & aligned;
  assign rword   = mem[widx];

  // Lane enables and lane-replicated store data for the access size
  always_comb begin
    be    = 4'b0000;
    wdata = data_in;
    unique case (size)
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{data_in[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_in[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Pick the addressed lanes and extend to a full word
  always_comb begin
    rbyte = rword[7:0];
    unique case (off)
      2'b00: rbyte = rword[7:0];
      2'b01: rbyte = rword[15:8];
      2'b10: rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = off[1] ? rword[31:16] : rword[15:0];
    ext   = rword;
    unique case (size)
      2'b00: ext = {{24{~uns & rbyte[7]}}, rbyte};
      2'b01: ext = {{16{~uns & rhalf[15]}}, rhalf};
      default: ext = rword;
    endcase
  end

  // Storage: sweep zeroes one word per cycle, otherwise lane-masked stores
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (in_clr) begin
        mem[cnt] <= '0;
      end else if (acc && str) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Clear sequencer and registered load/strobe outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      data_out <= '0;
      rd_valid <= 1'b0;
      misalign <= 1'b0;
    end else begin
      rd_valid <= acc & ld;
      misalign <= req & ~aligned;
      if (acc && ld) data_out <= ext;
      unique case (state)
        IDLE: begin
          if (clr_go) begin
            state <= CLEAR;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] par [DEPTH];
  logic [3:0] rpar;
  logic [3:0] lane_par;

  assign rpar = par[widx];

  // Recompute parity of the word being read for comparison
  always_comb begin
    lane_par = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      lane_par[i] = ^rword[8*i +: 8];
    end
  end

  // Parity bits follow the data writes, including the sweep
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (in_clr) begin
        par[cnt] <= 4'b0000;
      end else if (acc && str) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) par[widx][i] <= ^wdata[8*i +: 8];
        end
      end
    end
  end

  // Flag a load whose read lanes disagree with stored parity
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= acc & ld & (|((rpar ^ lane_par) & be));
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Bench for data_mem_bytelane: directed vector table, hand sequences for
// clear/reset timing, and random traffic against a byte-array model.
module tb_data_mem_bytelane;
  localparam int AW    = 10;
  localparam int DEPTH = 2**AW;
  localparam int NB    = DEPTH * 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sel;
  logic          str;
  logic          ld;
  logic          clr;
  logic [1:0]    size;
  logic          uns;
  logic [AW+1:0] addr;
  logic [31:0]   data_in;
  logic [31:0]   data_out;
  logic          rd_valid;
  logic          misalign;
  logic          busy;
`ifdef DMEM_PARITY_EN
  logic          parity_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  mref [NB];
  logic [31:0] exp_dout;
  logic        exp_valid;
  logic        exp_mis;

  typedef struct {
    logic        s;
    logic        st;
    logic        l;
    logic [1:0]  sz;
    logic        u;
    logic [11:0] a;
    logic [31:0] d;
    logic [31:0] e_out;
    logic        e_v;
    logic        e_m;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  data_mem_bytelane #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .sel(sel),
    .str(str),
    .ld(ld),
    .clr(clr),
    .size(size),
    .uns(uns),
    .addr(addr),
    .data_in(data_in),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .misalign(misalign),
`ifdef DMEM_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference behaviour: byte-addressed array, plain arithmetic extension
  task automatic model_op(input logic s, input logic st, input logic l,
                          input logic [1:0] sz, input logic u,
                          input logic [11:0] a, input logic [31:0] d);
    int n;
    longint unsigned v;
    longint unsigned mask;
    exp_valid = 1'b0;
    exp_mis   = 1'b0;
    if (!s || !(st || l)) return;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (sz == 2'd3 || (int'(a) % n) != 0) begin
      exp_mis = 1'b1;
      return;
    end
    if (l) begin
      v = 0;
      for (int k = 0; k < n; k++) v = v + (longint'(mref[int'(a) + k]) << (8 * k));
      mask = (64'd1 << (8 * n)) - 1;
      if (!u && v[8*n-1]) v = v | ~mask;
      exp_dout  = v[31:0];
      exp_valid = 1'b1;
    end
    if (st) begin
      for (int k = 0; k < n; k++) mref[int'(a) + k] = d[8*k +: 8];
    end
  endtask

  task automatic idle_inputs();
    sel = 1'b0; str = 1'b0; ld = 1'b0; clr = 1'b0;
    size = 2'b00; uns = 1'b0; addr = '0; data_in = '0;
  endtask

  // One access cycle: drive, update the model, step past the edge
  task automatic drive(input logic s, input logic st, input logic l,
                       input logic [1:0] sz, input logic u,
                       input logic [11:0] a, input logic [31:0] d);
    sel = s; str = st; ld = l; clr = 1'b0;
    size = sz; uns = u; addr = a; data_in = d;
    model_op(s, st, l, sz, u, a, d);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    int n;
    logic saw;
    idle_inputs();
    rst = 1'b1;
    exp_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data_out", data_out, 32'h0);
    chk("reset_rd_valid", {31'b0, rd_valid}, 32'h0);
    chk("reset_misalign", {31'b0, misalign}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;

    // Full clear sweep, with a load held high throughout
    sel = 1'b1; clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clear_busy_rise", {31'b0, busy}, 32'h1);
    ld = 1'b1; size = 2'b10; addr = 12'h010;
    n = 1;
    saw = 1'b0;
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      if (busy) n++;
      if (rd_valid || misalign) saw = 1'b1;
    end
    idle_inputs();
    chk("clear_busy_cycles", n, DEPTH);
    chk("clear_quiet", {31'b0, saw}, 32'h0);
    for (int i = 0; i < NB; i++) mref[i] = 8'h00;

    drive(1, 0, 1, 2'b10, 0, 12'h010, 32'h0);
    chk("clear_lw_data", data_out, 32'h0);
    chk("clear_lw_valid", {31'b0, rd_valid}, 32'h1);
    @(posedge clk);
    #1;
    chk("rd_valid_one_cycle", {31'b0, rd_valid}, 32'h0);

    // Directed vectors: s st l sz u addr din | data_out rd_valid misalign
    tbl.push_back('{1,1,0,2'd2,0,12'h028,32'hDEADBEEF,32'h00000000,0,0});
    tbl.push_back('{1,1,0,2'd0,0,12'h029,32'h00000055,32'h00000000,0,0});
    tbl.push_back('{1,0,1,2'd2,0,12'h028,32'h0,      32'hDEAD55EF,1,0});
    tbl.push_back('{1,1,0,2'd2,0,12'h050,32'h0000F080,32'hDEAD55EF,0,0});
    tbl.push_back('{1,0,1,2'd0,0,12'h050,32'h0,      32'hFFFFFF80,1,0});
    tbl.push_back('{1,0,1,2'd0,1,12'h050,32'h0,      32'h00000080,1,0});
    tbl.push_back('{1,0,1,2'd1,0,12'h050,32'h0,      32'hFFFFF080,1,0});
    tbl.push_back('{1,0,1,2'd1,1,12'h050,32'h0,      32'h0000F080,1,0});
    tbl.push_back('{1,0,1,2'd2,0,12'h052,32'h0,      32'h0000F080,0,1});
    tbl.push_back('{1,1,0,2'd1,0,12'h051,32'h00001234,32'h0000F080,0,1});
    tbl.push_back('{1,0,1,2'd2,0,12'h050,32'h0,      32'h0000F080,1,0});
    tbl.push_back('{1,1,0,2'd2,0,12'h060,32'h11111111,32'h0000F080,0,0});
    tbl.push_back('{1,1,1,2'd2,0,12'h060,32'hCAFEBABE,32'h11111111,1,0});
    tbl.push_back('{1,0,1,2'd2,0,12'h060,32'h0,      32'hCAFEBABE,1,0});
    tbl.push_back('{1,0,1,2'd3,0,12'h060,32'h0,      32'hCAFEBABE,0,1});
    tbl.push_back('{1,0,1,2'd0,0,12'h063,32'h0,      32'hFFFFFFCA,1,0});
    tbl.push_back('{1,0,1,2'd1,1,12'h062,32'h0,      32'h0000CAFE,1,0});
    tbl.push_back('{1,1,0,2'd1,0,12'h02A,32'h00008001,32'h0000CAFE,0,0});
    tbl.push_back('{0,1,0,2'd2,0,12'h028,32'h00000000,32'h0000CAFE,0,0});
    tbl.push_back('{1,0,1,2'd2,0,12'h028,32'h0,      32'h800155EF,1,0});
    tbl.push_back('{1,0,1,2'd0,1,12'h028,32'h0,      32'h000000EF,1,0});

    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].st, tbl[i].l, tbl[i].sz, tbl[i].u,
            tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d_data_out", i), data_out, tbl[i].e_out);
      chk($sformatf("vec%0d_rd_valid", i), {31'b0, rd_valid},
          {31'b0, tbl[i].e_v});
      chk($sformatf("vec%0d_misalign", i), {31'b0, misalign},
          {31'b0, tbl[i].e_m});
    end

    // Random traffic against the model
    exp_dout = data_out === 32'h000000EF ? 32'h000000EF : 32'h000000EF;
    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      a = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, NB - 1))
                                      : 12'($urandom_range(0, 255));
      drive(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
            2'($urandom), 1'($urandom), a, $urandom);
      chk($sformatf("rnd%0d_data_out", i), data_out, exp_dout);
      chk($sformatf("rnd%0d_rd_valid", i), {31'b0, rd_valid},
          {31'b0, exp_valid});
      chk($sformatf("rnd%0d_misalign", i), {31'b0, misalign},
          {31'b0, exp_mis});
    end

    // clr without sel must not start a sweep
    clr = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    chk("clr_needs_sel", {31'b0, busy}, 32'h0);

    // Mid-sweep reset; the sweep start also carries a misaligned load
    drive(1, 1, 0, 2'b10, 0, 12'h050, 32'h13572468);
    drive(1, 1, 0, 2'b10, 0, 12'h010, 32'hA5A5A5A5);
    drive(1, 1, 0, 2'b10, 0, 12'h014, 32'h0BADF00D);
    sel = 1'b1; clr = 1'b1; ld = 1'b1; size = 2'b11; addr = 12'h052;
    @(posedge clk);
    #1;
    clr = 1'b0; size = 2'b10; addr = 12'h050;
    chk("sweep_start_busy", {31'b0, busy}, 32'h1);
    chk("clr_wins_no_misalign", {31'b0, misalign}, 32'h0);
    chk("clr_wins_no_rd_valid", {31'b0, rd_valid}, 32'h0);
    saw = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (rd_valid || misalign) saw = 1'b1;
    end
    chk("sweep_mid_busy", {31'b0, busy}, 32'h1);
    chk("sweep_loads_ignored", {31'b0, saw}, 32'h0);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_data_out", data_out, 32'h0);
    for (int i = 0; i < 20; i++) mref[i] = 8'h00;
    drive(1, 0, 1, 2'b10, 0, 12'h010, 32'h0);
    chk("swept_word4", data_out, 32'h0);
    chk("swept_word4_valid", {31'b0, rd_valid}, 32'h1);
    drive(1, 0, 1, 2'b10, 0, 12'h050, 32'h0);
    chk("kept_word20", data_out, 32'h13572468);
    drive(1, 0, 1, 2'b10, 0, 12'h014, 32'h0);
    chk("kept_word5", data_out, 32'h0BADF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
